// File: rtl/rtc_bus_sequencer_if.sv
// Command, read-return and RTC pin bundle for rtc_bus_sequencer.
// The master modport is the sequencer's view; slave is the command source / bus side.
interface rtc_bus_sequencer_if #(
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [DATA_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_data;
    logic [LEN_W-1:0]  cmd_len;
    logic              abort;

    logic [DATA_W-1:0] bus_in;
    logic [DATA_W-1:0] bus_out;
    logic              bus_oe;
    logic              A_D;
    logic              CS;
    logic              RD;
    logic              WR;

    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;
    logic [LEN_W-1:0]  rd_index;
    logic              busy;
    logic              done;
    logic              aborted;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_len, abort, bus_in,
        output cmd_ready, bus_out, bus_oe, A_D, CS, RD, WR,
        output rd_valid, rd_data, rd_index, busy, done, aborted
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_data, cmd_len, abort, bus_in,
        input  cmd_ready, bus_out, bus_oe, A_D, CS, RD, WR,
        input  rd_valid, rd_data, rd_index, busy, done, aborted
    );
endinterface

// File: rtl/rtc_bus_sequencer.sv
// Master for the RTC multiplexed A/D bus: single writes and burst reads with
// programmable setup/pulse/hold/gap timing; pins are registered straight from the FSM.
module rtc_bus_sequencer #(
    parameter int DATA_W    = 8,
    parameter int T_SETUP   = 1,
    parameter int T_PULSE   = 4,
    parameter int T_HOLD    = 1,
    parameter int T_GAP     = 2,
    parameter int MAX_BURST = 16,
    parameter int LEN_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    rtc_bus_sequencer_if.master  bus_if
);

    localparam int T_MAX_SP = (T_SETUP > T_PULSE) ? T_SETUP : T_PULSE;
    localparam int T_MAX_HG = (T_HOLD > T_GAP) ? T_HOLD : T_GAP;
    localparam int T_MAX    = (T_MAX_SP > T_MAX_HG) ? T_MAX_SP : T_MAX_HG;
    localparam int CNT_W    = $clog2(T_MAX) + 1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_A_SETUP, S_A_PULSE, S_A_HOLD, S_A_GAP,
        S_D_SETUP, S_D_PULSE, S_D_HOLD, S_D_GAP
    } state_e;

    typedef struct packed {
        logic              cs;
        logic              rd;
        logic              wr;
        logic              a_d;
        logic              oe;
        logic [DATA_W-1:0] dout;
    } pins_t;

    localparam pins_t IDLE_PINS = '{cs: 1'b1, rd: 1'b1, wr: 1'b1, a_d: 1'b1, oe: 1'b0, dout: '0};

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    pins_t             pins_q;
    logic [DATA_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              write_q;
    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  idx_q;
    logic              abort_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;
    logic [LEN_W-1:0]  rd_index_q;
    logic              done_q;
    logic              aborted_q;

    logic [LEN_W-1:0]  len_eff;
    logic [LEN_W-1:0]  idx_inc;
    logic [DATA_W-1:0] addr_inc;
    logic              more;
    logic              stop;

    function automatic state_e succ(state_e s);
        case (s)
            S_A_SETUP: return S_A_PULSE;
            S_A_PULSE: return S_A_HOLD;
            S_A_HOLD:  return S_A_GAP;
            S_A_GAP:   return S_D_SETUP;
            S_D_SETUP: return S_D_PULSE;
            S_D_PULSE: return S_D_HOLD;
            S_D_HOLD:  return S_D_GAP;
            default:   return S_IDLE;
        endcase
    endfunction

    // Count loaded on entry; the state is left when it reaches zero.
    function automatic logic [CNT_W-1:0] dur(state_e s);
        case (s)
            S_A_SETUP, S_D_SETUP: return CNT_W'(T_SETUP - 1);
            S_A_PULSE, S_D_PULSE: return CNT_W'(T_PULSE - 1);
            S_A_HOLD,  S_D_HOLD:  return CNT_W'(T_HOLD - 1);
            S_A_GAP,   S_D_GAP:   return CNT_W'(T_GAP - 1);
            default:              return '0;
        endcase
    endfunction

    function automatic pins_t pins_for(state_e s, logic wr_cmd,
                                       logic [DATA_W-1:0] a, logic [DATA_W-1:0] d);
        pins_t p;
        p = IDLE_PINS;
        case (s)
            S_A_SETUP, S_A_HOLD: begin
                p.cs = 1'b0; p.a_d = 1'b0; p.oe = 1'b1; p.dout = a;
            end
            S_A_PULSE: begin
                p.cs = 1'b0; p.a_d = 1'b0; p.oe = 1'b1; p.dout = a; p.wr = 1'b0;
            end
            S_A_GAP: p.a_d = 1'b0;
            S_D_SETUP, S_D_HOLD: begin
                p.cs = 1'b0; p.oe = wr_cmd; p.dout = wr_cmd ? d : '0;
            end
            S_D_PULSE: begin
                p.cs = 1'b0; p.oe = wr_cmd; p.dout = wr_cmd ? d : '0;
                if (wr_cmd) p.wr = 1'b0;
                else        p.rd = 1'b0;
            end
            default: ;
        endcase
        return p;
    endfunction

    // NOTE: every branch assigns len_eff, so this combinational block cannot infer a latch.
    always_comb begin
        if (bus_if.cmd_write || bus_if.cmd_len == '0)
            len_eff = LEN_W'(1);
        else if (bus_if.cmd_len > LEN_W'(MAX_BURST))
            len_eff = LEN_W'(MAX_BURST);
        else
            len_eff = bus_if.cmd_len;
    end

    assign idx_inc  = idx_q + 1'b1;
    assign addr_inc = addr_q + 1'b1;
    assign more     = idx_inc < len_q;
    assign stop     = abort_q | bus_if.abort;

    // NOTE: non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            pins_q     <= IDLE_PINS;
            addr_q     <= '0;
            data_q     <= '0;
            write_q    <= 1'b0;
            len_q      <= '0;
            idx_q      <= '0;
            abort_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            rd_index_q <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            if (state_q != S_IDLE && bus_if.abort) abort_q <= 1'b1;

            case (state_q)
                S_IDLE: begin
                    abort_q <= 1'b0;
                    if (bus_if.cmd_valid) begin
                        addr_q  <= bus_if.cmd_addr;
                        data_q  <= bus_if.cmd_data;
                        write_q <= bus_if.cmd_write;
                        len_q   <= len_eff;
                        idx_q   <= '0;
                        state_q <= S_A_SETUP;
                        cnt_q   <= dur(S_A_SETUP);
                        pins_q  <= pins_for(S_A_SETUP, bus_if.cmd_write,
                                            bus_if.cmd_addr, bus_if.cmd_data);
                    end
                end
                default: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else if (state_q == S_D_GAP) begin
                        // An abort seen on the final gap cycle still counts.
                        if (more && !stop) begin
                            addr_q  <= addr_inc;
                            idx_q   <= idx_inc;
                            state_q <= S_A_SETUP;
                            cnt_q   <= dur(S_A_SETUP);
                            pins_q  <= pins_for(S_A_SETUP, write_q, addr_inc, data_q);
                        end else begin
                            state_q   <= S_IDLE;
                            pins_q    <= IDLE_PINS;
                            done_q    <= 1'b1;
                            aborted_q <= more && stop;
                        end
                    end else begin
                        if (state_q == S_D_PULSE && !write_q) begin
                            rd_valid_q <= 1'b1;
                            rd_data_q  <= bus_if.bus_in;
                            rd_index_q <= idx_q;
                        end
                        state_q <= succ(state_q);
                        cnt_q   <= dur(succ(state_q));
                        pins_q  <= pins_for(succ(state_q), write_q, addr_q, data_q);
                    end
                end
            endcase
        end
    end

    assign bus_if.cmd_ready = (state_q == S_IDLE);
    assign bus_if.busy      = (state_q != S_IDLE);
    assign bus_if.CS        = pins_q.cs;
    assign bus_if.RD        = pins_q.rd;
    assign bus_if.WR        = pins_q.wr;
    assign bus_if.A_D       = pins_q.a_d;
    assign bus_if.bus_oe    = pins_q.oe;
    assign bus_if.bus_out   = pins_q.dout;
    assign bus_if.rd_valid  = rd_valid_q;
    assign bus_if.rd_data   = rd_data_q;
    assign bus_if.rd_index  = rd_index_q;
    assign bus_if.done      = done_q;
    assign bus_if.aborted   = aborted_q;

endmodule

// File: tb/tb_rtc_bus_sequencer.sv
// Randomized bench for rtc_bus_sequencer: every cycle of every command is compared
// against a pin trace computed arithmetically from the access timing rules.
module tb_rtc_bus_sequencer;

    localparam int DW = 8;
    localparam int MB = 16;
    localparam int LW = $clog2(MB + 1);

    typedef struct packed {
        logic          cs;
        logic          rd;
        logic          wr;
        logic          ad;
        logic          oe;
        logic [DW-1:0] bus_out;
        logic          rd_valid;
        logic [DW-1:0] rd_data;
        logic [LW-1:0] rd_index;
        logic          busy;
        logic          done;
        logic          aborted;
        logic          ready;
    } obs_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          sel;
    logic          cmd_valid, cmd_write, abort;
    logic [DW-1:0] cmd_addr, cmd_data, bus_in;
    logic [LW-1:0] cmd_len;

    int ts, tp, th, tg;
    logic [DW-1:0] rdv [0:MB-1];
    int n_checks = 0;
    int n_errors = 0;

    rtc_bus_sequencer_if #(.DATA_W(DW), .MAX_BURST(MB)) if_a ();
    rtc_bus_sequencer_if #(.DATA_W(DW), .MAX_BURST(MB)) if_b ();

    rtc_bus_sequencer #(.DATA_W(DW), .MAX_BURST(MB)) dut_a (
        .clk_i(clk), .reset_ni(reset_n), .bus_if(if_a)
    );

    rtc_bus_sequencer #(.DATA_W(DW), .T_SETUP(2), .T_PULSE(1), .T_HOLD(3), .T_GAP(1),
                        .MAX_BURST(MB)) dut_b (
        .clk_i(clk), .reset_ni(reset_n), .bus_if(if_b)
    );

    assign if_a.cmd_valid = cmd_valid && !sel;
    assign if_b.cmd_valid = cmd_valid && sel;
    assign if_a.cmd_write = cmd_write;  assign if_b.cmd_write = cmd_write;
    assign if_a.cmd_addr  = cmd_addr;   assign if_b.cmd_addr  = cmd_addr;
    assign if_a.cmd_data  = cmd_data;   assign if_b.cmd_data  = cmd_data;
    assign if_a.cmd_len   = cmd_len;    assign if_b.cmd_len   = cmd_len;
    assign if_a.abort     = abort;      assign if_b.abort     = abort;
    assign if_a.bus_in    = bus_in;     assign if_b.bus_in    = bus_in;

    obs_t obs_a, obs_b;
    assign obs_a = {if_a.CS, if_a.RD, if_a.WR, if_a.A_D, if_a.bus_oe, if_a.bus_out,
                    if_a.rd_valid, if_a.rd_data, if_a.rd_index,
                    if_a.busy, if_a.done, if_a.aborted, if_a.cmd_ready};
    assign obs_b = {if_b.CS, if_b.RD, if_b.WR, if_b.A_D, if_b.bus_oe, if_b.bus_out,
                    if_b.rd_valid, if_b.rd_data, if_b.rd_index,
                    if_b.busy, if_b.done, if_b.aborted, if_b.cmd_ready};

    task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic obs_t idle_exp(bit done_now, bit abt);
        obs_t e;
        e = '0;
        e.cs = 1'b1; e.rd = 1'b1; e.wr = 1'b1; e.ad = 1'b1;
        e.ready = 1'b1; e.done = done_now; e.aborted = done_now && abt;
        return e;
    endfunction

    function automatic int eff_len(bit wr, int len);
        if (wr || len == 0) return 1;
        if (len > MB) return MB;
        return len;
    endfunction

    // Expected pins in cycle c (1 = first cycle after acceptance) of an n-access command.
    function automatic obs_t model(int c, int n, bit wr, logic [DW-1:0] a,
                                   logic [DW-1:0] d, bit abt);
        obs_t e;
        int L, H, k, o, p;
        bit half, gap, pulse;
        logic [DW-1:0] ak;
        L = 2 * (ts + tp + th + tg);
        H = L / 2;
        if (c > n * L) return idle_exp(c == n * L + 1, abt);
        k = (c - 1) / L;
        o = (c - 1) % L;
        half  = (o >= H);
        p     = o % H;
        gap   = (p >= ts + tp + th);
        pulse = (p >= ts) && (p < ts + tp);
        ak    = a + DW'(k);
        e = '0;
        e.busy     = 1'b1;
        e.cs       = gap;
        e.ad       = half;
        e.wr       = !(pulse && (!half || wr));
        e.rd       = !(pulse && half && !wr);
        e.oe       = !gap && (!half || wr);
        e.bus_out  = e.oe ? (half ? d : ak) : '0;
        e.rd_valid = half && !wr && (p == ts + tp);
        e.rd_data  = e.rd_valid ? rdv[k] : '0;
        e.rd_index = e.rd_valid ? LW'(k) : '0;
        return e;
    endfunction

    function automatic obs_t masked(obs_t g, obs_t e);
        if (!e.oe)       g.bus_out  = '0;
        if (!e.rd_valid) begin g.rd_data = '0; g.rd_index = '0; end
        if (!e.done)     g.aborted  = 1'b0;
        return g;
    endfunction

    // abort_cyc / poke_cyc: 0 = none, else the busy cycle in which the input is raised.
    task automatic run_cmd(bit s, bit wr, logic [DW-1:0] a, logic [DW-1:0] d, int len,
                           int abort_cyc, int poke_cyc, bit idle_abort);
        int L, H, neff, n, ka, w, o, k;
        bit abt;
        obs_t got, exp;
        sel = s;
        if (s) begin ts = 2; tp = 1; th = 3; tg = 1; end
        else   begin ts = 1; tp = 4; th = 1; tg = 2; end
        L = 2 * (ts + tp + th + tg);
        H = L / 2;
        neff = eff_len(wr, len);
        n = neff;
        abt = 1'b0;
        if (abort_cyc > 0) begin
            ka = (abort_cyc - 1) / L;
            if (ka + 1 < neff) begin n = ka + 1; abt = 1'b1; end
        end
        for (int i = 0; i < MB; i++) rdv[i] = DW'($urandom);
        cmd_write = wr; cmd_addr = a; cmd_data = d; cmd_len = LW'(len);
        abort = idle_abort;
        cmd_valid = 1'b1;
        w = 0;
        while (!(s ? if_b.cmd_ready : if_a.cmd_ready) && w < 400) begin
            @(negedge clk);
            w++;
        end
        if (w >= 400) begin
            check("ready_timeout", 64'(0), 64'(1));
            cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0; abort = 1'b0;
        cmd_write = 1'($urandom); cmd_addr = DW'($urandom);
        cmd_data = DW'($urandom); cmd_len = LW'($urandom);
        for (int c = 1; c <= n * L + 1; c++) begin
            @(negedge clk);
            exp = model(c, n, wr, a, d, abt);
            got = masked(s ? obs_b : obs_a, exp);
            check($sformatf("%s c%0d", s ? "b" : "a", c), 64'(got), 64'(exp));
            bus_in = DW'($urandom);
            if (c <= n * L) begin
                o = (c - 1) % L;
                k = (c - 1) / L;
                if (!wr && o == H + ts + tp - 1) bus_in = rdv[k];
            end
            abort     = (c == abort_cyc);
            cmd_valid = (c == poke_cyc);
        end
        abort = 1'b0;
        cmd_valid = 1'b0;
    endtask

    initial begin
        int wr, len, neff, ab, pk;
        reset_n = 1'b0; sel = 1'b0;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_data = '0;
        cmd_len = '0; abort = 1'b0; bus_in = '0;
        ts = 1; tp = 4; th = 1; tg = 2;
        #12;
        check("reset_a", 64'(masked(obs_a, idle_exp(0, 0))), 64'(idle_exp(0, 0)));
        check("reset_b", 64'(masked(obs_b, idle_exp(0, 0))), 64'(idle_exp(0, 0)));
        check("reset_rd_data", 64'({if_a.rd_data, if_a.rd_index, if_a.aborted}), 64'(0));
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_cmd(0, 1, 8'h21, 8'h45, 1, 0, 0, 0);
        run_cmd(0, 0, 8'h21, 8'h00, 1, 0, 0, 1);
        run_cmd(0, 0, 8'hFE, 8'h00, 3, 0, 20, 0);
        run_cmd(0, 0, 8'h10, 8'h00, 5, 16 + 5, 0, 0);
        run_cmd(0, 0, 8'h30, 8'h00, 5, 4 * 16 + 3, 0, 0);
        run_cmd(0, 0, 8'h40, 8'h00, 4, 2 * 16, 0, 0);

        // Reset mid write strobe must release the bus at once.
        sel = 1'b0;
        cmd_write = 1'b1; cmd_addr = 8'h55; cmd_data = 8'hAA; cmd_len = '0;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pre_reset_wr", 64'({if_a.CS, if_a.WR, if_a.bus_oe}), 64'(3'b001));
        reset_n = 1'b0;
        #1;
        check("async_reset", 64'({if_a.CS, if_a.WR, if_a.bus_oe, if_a.busy}), 64'(4'b1100));
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        check("post_reset", 64'(masked(obs_a, idle_exp(0, 0))), 64'(idle_exp(0, 0)));
        run_cmd(0, 0, 8'h77, 8'h00, 2, 0, 0, 0);

        run_cmd(1, 1, 8'h21, 8'h45, 1, 0, 0, 0);
        run_cmd(1, 0, 8'h05, 8'h00, 0, 0, 0, 0);
        run_cmd(1, 0, 8'hF8, 8'h00, 20, 0, 0, 0);

        for (int i = 0; i < 24; i++) begin
            wr   = int'($urandom_range(0, 3) == 0);
            len  = int'($urandom_range(0, MB + 3));
            neff = eff_len(wr != 0, len);
            ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, neff * 16)) : 0;
            pk   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, neff * 16)) : 0;
            run_cmd(0, wr != 0, DW'($urandom), DW'($urandom), len, ab, pk, $urandom_range(0, 1) != 0);
        end
        for (int i = 0; i < 8; i++) begin
            wr   = int'($urandom_range(0, 3) == 0);
            len  = int'($urandom_range(0, MB + 3));
            neff = eff_len(wr != 0, len);
            ab   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, neff * 14)) : 0;
            run_cmd(1, wr != 0, DW'($urandom), DW'($urandom), len, ab, 0, 0);
        end

        @(negedge clk);
        check("final_idle_a", 64'({if_a.busy, if_a.cmd_ready}), 64'(2'b01));
        check("final_idle_b", 64'({if_b.busy, if_b.cmd_ready}), 64'(2'b01));
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
